// File: rtl/complex_mac_scheduler_if.sv
// complex_mac_scheduler_if: operand fetch, multiplier and result handshake signals of the MAC scheduler
interface complex_mac_scheduler_if #(
    parameter int QI    = 4,
    parameter int QF    = 4,
    parameter int N_MAX = 16,
    parameter int AW    = $clog2(N_MAX)
);
    localparam int W = QI + QF;
    logic                start;
    logic [AW:0]         len;
    logic                busy;
    logic                rd_en;
    logic [AW-1:0]       x_addr, h_addr;
    logic signed [W-1:0] x_Re, x_Im, h_Re, h_Im;
    logic signed [W-1:0] m_a_Re, m_a_Im, m_b_Re, m_b_Im;
    logic signed [W-1:0] m_y_Re, m_y_Im;
    logic                m_ovf_mult, m_ovf_add_sub;
    logic signed [W-1:0] y_Re, y_Im;
    logic                y_valid, y_ready, ovf;
    modport slave (
        input  start, len, x_Re, x_Im, h_Re, h_Im, m_y_Re, m_y_Im, m_ovf_mult, m_ovf_add_sub, y_ready,
        output busy, rd_en, x_addr, h_addr, m_a_Re, m_a_Im, m_b_Re, m_b_Im, y_Re, y_Im, y_valid, ovf
    );
    modport master (
        output start, len, x_Re, x_Im, h_Re, h_Im, m_y_Re, m_y_Im, m_ovf_mult, m_ovf_add_sub, y_ready,
        input  busy, rd_en, x_addr, h_addr, m_a_Re, m_a_Im, m_b_Re, m_b_Im, y_Re, y_Im, y_valid, ovf
    );
endinterface

// File: rtl/complex_mac_scheduler.sv
// complex_mac_scheduler: complex dot-product sequencer around a shared multiplier; CMAC_CONJ_EN conjugates h.
module complex_mac_scheduler #(
    parameter int QI    = 4,
    parameter int QF    = 4,
    parameter int N_MAX = 16,
    parameter int AW    = $clog2(N_MAX)
) (
    input logic                    clk,
    input logic                    rst_n,
    complex_mac_scheduler_if.slave bus
);
    localparam int W = QI + QF;
    localparam int AW_ACC = W + AW + 1;
    localparam logic signed [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [AW:0] LEN_MAX = (AW+1)'(N_MAX);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, MULT, ACC, OUT} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            k_q, k_d;
    logic [AW:0]              len_q, len_d;
    logic signed [W-1:0]      a_re_q, a_re_d, a_im_q, a_im_d, b_re_q, b_re_d, b_im_q, b_im_d;
    logic signed [W-1:0]      p_re_q, p_re_d, p_im_q, p_im_d;
    logic signed [AW_ACC-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic                     ovf_q, ovf_d;
    logic signed [W-1:0]      h_im_b;
    logic                     conj_sat, sat_re, sat_im, last;

`ifdef CMAC_CONJ_EN
    assign conj_sat = bus.h_Im == Q_MIN;
    assign h_im_b = conj_sat ? Q_MAX : -bus.h_Im;
`else
    assign conj_sat = 1'b0;
    assign h_im_b = bus.h_Im;
`endif

    // {saturated flag, QI.QF value}: in range iff all bits above the result sign agree with it
    function automatic logic [W:0] sat(input logic signed [AW_ACC-1:0] v);
        logic fits;
        fits = (v[AW_ACC-1:W-1] == '0) || (v[AW_ACC-1:W-1] == '1);
        return fits ? {1'b0, v[W-1:0]} : {1'b1, (v[AW_ACC-1] ? Q_MIN : Q_MAX)};
    endfunction

    assign last = {1'b0, k_q} == len_q - 1'b1;

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        len_d = len_q;
        a_re_d = a_re_q;
        a_im_d = a_im_q;
        b_re_d = b_re_q;
        b_im_d = b_im_q;
        p_re_d = p_re_q;
        p_im_d = p_im_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        ovf_d = ovf_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                acc_re_d = '0;
                acc_im_d = '0;
                k_d = '0;
                ovf_d = 1'b0;
                len_d = bus.len > LEN_MAX ? LEN_MAX : bus.len;
                state_d = bus.len == '0 ? OUT : FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                a_re_d = bus.x_Re;
                a_im_d = bus.x_Im;
                b_re_d = bus.h_Re;
                b_im_d = h_im_b;
                ovf_d = ovf_q | conj_sat;
                state_d = MULT;
            end
            MULT: begin
                p_re_d = bus.m_y_Re;
                p_im_d = bus.m_y_Im;
                ovf_d = ovf_q | bus.m_ovf_mult | bus.m_ovf_add_sub;
                state_d = ACC;
            end
            ACC: begin
                acc_re_d = acc_re_q + AW_ACC'(p_re_q);
                acc_im_d = acc_im_q + AW_ACC'(p_im_q);
                k_d = last ? k_q : k_q + 1'b1;
                state_d = last ? OUT : FETCH;
            end
            OUT: state_d = bus.y_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q <= '0;
            len_q <= '0;
            a_re_q <= '0;
            a_im_q <= '0;
            b_re_q <= '0;
            b_im_q <= '0;
            p_re_q <= '0;
            p_im_q <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            len_q <= len_d;
            a_re_q <= a_re_d;
            a_im_q <= a_im_d;
            b_re_q <= b_re_d;
            b_im_q <= b_im_d;
            p_re_q <= p_re_d;
            p_im_q <= p_im_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.busy = state_q != IDLE;
    assign bus.rd_en = state_q == FETCH;
    assign bus.x_addr = k_q;
    assign bus.h_addr = k_q;
    assign bus.m_a_Re = a_re_q;
    assign bus.m_a_Im = a_im_q;
    assign bus.m_b_Re = b_re_q;
    assign bus.m_b_Im = b_im_q;
    assign {sat_re, bus.y_Re} = sat(acc_re_q);
    assign {sat_im, bus.y_Im} = sat(acc_im_q);
    assign bus.y_valid = state_q == OUT;
    assign bus.ovf = ovf_q | sat_re | sat_im;
endmodule

// File: tb/tb_complex_mac_scheduler.sv
// tb_complex_mac_scheduler: random and directed runs checked every cycle against a behavioural dot-product model
module tb_complex_mac_scheduler;
    localparam int QI = 4, QF = 4, N_MAX = 16, AW = $clog2(N_MAX);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, errors = 0;
    logic [7:0] xr_mem [N_MAX];
    logic [7:0] xi_mem [N_MAX];
    logic [7:0] hr_mem [N_MAX];
    logic [7:0] hi_mem [N_MAX];
    bit active = 0, just_reset = 0, ev = 0, erd = 0;
    int cyc = 0, lenr = 0, ey_re = 0, ey_im = 0, eovf = 0, rd_pulses = 0;
    int yr, yi, yo, lat;

    always #5 clk = ~clk;

    complex_mac_scheduler_if #(.QI(QI), .QF(QF), .N_MAX(N_MAX), .AW(AW)) bus ();
    complex_mac_scheduler #(.QI(QI), .QF(QF), .N_MAX(N_MAX), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit oor(input int v);
        return v < -128 || v > 127;
    endfunction

    // Exact Q4.4 complex multiplier: floor-truncated products, wrapped sums, overflow flags
    function automatic logic [17:0] cmul(input logic [7:0] ar, input logic [7:0] ai, input logic [7:0] br, input logic [7:0] bi);
        int p0, p1, p2, p3, re, im;
        p0 = (int'($signed(ar)) * int'($signed(br))) >>> QF;
        p1 = (int'($signed(ai)) * int'($signed(bi))) >>> QF;
        p2 = (int'($signed(ar)) * int'($signed(bi))) >>> QF;
        p3 = (int'($signed(ai)) * int'($signed(br))) >>> QF;
        re = p0 - p1;
        im = p2 + p3;
        return {oor(p0) | oor(p1) | oor(p2) | oor(p3), oor(re) | oor(im), 8'(re), 8'(im)};
    endfunction

    always_comb {bus.m_ovf_mult, bus.m_ovf_add_sub, bus.m_y_Re, bus.m_y_Im} =
        cmul(bus.m_a_Re, bus.m_a_Im, bus.m_b_Re, bus.m_b_Im);

    // Buffers return data only in the cycle after rd_en; otherwise junk
    always @(posedge clk) begin
        bus.x_Re <= bus.rd_en ? xr_mem[bus.x_addr] : 8'($urandom);
        bus.x_Im <= bus.rd_en ? xi_mem[bus.x_addr] : 8'($urandom);
        bus.h_Re <= bus.rd_en ? hr_mem[bus.h_addr] : 8'($urandom);
        bus.h_Im <= bus.rd_en ? hi_mem[bus.h_addr] : 8'($urandom);
    end

    task automatic compute_ref();
        int sr = 0, si = 0;
        logic [7:0] bi;
        logic [17:0] r;
        eovf = 0;
        for (int k = 0; k < lenr; k++) begin
            bi = hi_mem[k];
`ifdef CMAC_CONJ_EN
            if (bi == 8'h80) begin
                bi = 8'h7f;
                eovf = 1;
            end else bi = -bi;
`endif
            r = cmul(xr_mem[k], xi_mem[k], hr_mem[k], bi);
            if (r[17] || r[16]) eovf = 1;
            sr += int'($signed(r[15:8]));
            si += int'($signed(r[7:0]));
        end
        ey_re = sr > 127 ? 127 : sr < -128 ? -128 : sr;
        ey_im = si > 127 ? 127 : si < -128 ? -128 : si;
        if (ey_re != sr || ey_im != si) eovf = 1;
    endtask

    always @(negedge clk) begin
        if (bus.rd_en) rd_pulses++;
        if (just_reset) begin
            chk("rst_y_re", $signed(bus.y_Re), 0);
            chk("rst_y_im", $signed(bus.y_Im), 0);
            chk("rst_ovf", bus.ovf, 0);
            chk("rst_addr", bus.x_addr | bus.h_addr, 0);
            chk("rst_m_ops", bus.m_a_Re | bus.m_a_Im | bus.m_b_Re | bus.m_b_Im, 0);
        end
        if (!active) begin
            chk("idle_busy", bus.busy, 0);
            chk("idle_rd_en", bus.rd_en, 0);
            chk("idle_y_valid", bus.y_valid, 0);
        end else begin
            ev = cyc >= 4 * lenr + 1;
            erd = cyc <= 4 * lenr && cyc % 4 == 1;
            chk("busy", bus.busy, 1);
            chk("rd_en", bus.rd_en, erd);
            if (erd) begin
                chk("x_addr", bus.x_addr, (cyc - 1) / 4);
                chk("h_addr", bus.h_addr, (cyc - 1) / 4);
            end
            chk("y_valid", bus.y_valid, ev);
            if (ev) begin
                chk("y_re", $signed(bus.y_Re), ey_re);
                chk("y_im", $signed(bus.y_Im), ey_im);
                chk("ovf", bus.ovf, eovf);
            end
        end
        just_reset = 0;
        if (!rst_n) begin
            active = 0;
            just_reset = 1;
        end else if (!active) begin
            if (bus.start) begin
                lenr = bus.len > N_MAX ? N_MAX : int'(bus.len);
                compute_ref();
                active = 1;
                cyc = 1;
            end
        end else if (ev && bus.y_ready) active = 0;
        else cyc++;
    end

    task automatic fill(input logic [7:0] xr, input logic [7:0] xi, input logic [7:0] hr, input logic [7:0] hi);
        for (int k = 0; k < N_MAX; k++) begin
            xr_mem[k] = xr;
            xi_mem[k] = xi;
            hr_mem[k] = hr;
            hi_mem[k] = hi;
        end
    endtask

    function automatic logic [7:0] rv();
        int s;
        s = $urandom_range(0, 9);
        return s == 0 ? 8'h80 : s == 1 ? 8'h7f : 8'($urandom);
    endfunction

    task automatic run(input int l, input int hold, input bit poke, input bit hs_start, input bit rnd);
        rd_pulses = 0;
        bus.len = (AW+1)'(l);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.y_valid && lat < 200) begin
            bus.start = poke && lat == 3;
            bus.y_ready = rnd && $urandom_range(0, 1) == 1;
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        bus.y_ready = 1'b0;
        if (!bus.y_valid) chk("y_valid_timeout", 0, 1);
        yr = $signed(bus.y_Re);
        yi = $signed(bus.y_Im);
        yo = bus.ovf;
        repeat (hold) begin @(posedge clk); #1; end
        bus.y_ready = 1'b1;
        bus.start = hs_start;
        @(posedge clk); #1;
        bus.y_ready = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.len = '0;
        bus.y_ready = 1'b0;
        fill(8'h10, 8'h10, 8'h20, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(1, 0, 0, 0, 0);
        chk("s1_y_re", yr, 32);
        chk("s1_y_im", yi, 32);
        chk("s1_ovf", yo, 0);
        chk("s1_latency", lat, 5);
        chk("s1_reads", rd_pulses, 1);
        fill(8'h10, 8'h00, 8'h18, 8'h08);
        run(4, 0, 0, 0, 0);
        chk("s2_y_re", yr, 96);
`ifdef CMAC_CONJ_EN
        chk("s2_y_im", yi, -32);
`else
        chk("s2_y_im", yi, 32);
`endif
        chk("s2_latency", lat, 17);
        chk("s2_reads", rd_pulses, 4);
        fill(8'h20, 8'h00, 8'h30, 8'h00);
        run(4, 0, 0, 0, 0);
        chk("s3_y_re", yr, 127);
        chk("s3_y_im", yi, 0);
        chk("s3_ovf", yo, 1);
        run(0, 0, 0, 0, 0);
        chk("s4_len0_latency", lat, 1);
        chk("s4_len0_y", yr | yi, 0);
        chk("s4_len0_reads", rd_pulses, 0);
        run(20, 0, 0, 0, 0);
        chk("s4_len20_reads", rd_pulses, 16);
        chk("s4_len20_latency", lat, 65);
        chk("s4_len20_y_re", yr, 127);
        fill(8'h10, 8'h00, 8'h18, 8'h00);
        run(4, 3, 1, 1, 0);
        chk("s5_y_re", yr, 96);
        chk("s5_busy_after", bus.busy, 0);
        bus.len = 5'd4;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("s6_busy", bus.busy, 0);
        chk("s6_m_a_re", $signed(bus.m_a_Re), 0);
        fill(8'h10, 8'h10, 8'h20, 8'h00);
        run(1, 0, 0, 0, 0);
        chk("s6_y_re", yr, 32);
        chk("s6_y_im", yi, 32);
        fill(8'h10, 8'h00, 8'h00, 8'h10);
        run(1, 0, 0, 0, 0);
        chk("s7_y_re", yr, 0);
`ifdef CMAC_CONJ_EN
        chk("s7_y_im", yi, -16);
`else
        chk("s7_y_im", yi, 16);
`endif
        repeat (40) begin
            for (int k = 0; k < N_MAX; k++) begin
                xr_mem[k] = rv();
                xi_mem[k] = rv();
                hr_mem[k] = rv();
                hi_mem[k] = rv();
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            run($urandom_range(0, 20), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        repeat (2) begin @(posedge clk); #1; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
